// File: rtl/fsic_pkg.sv
// Shared definitions for the FSIC Wishbone arbiter: FSM encoding, FSIC address map
// and a small one-hot helper.
package fsic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  localparam logic [31:0] FSIC_AA_BASE       = 32'h3000_0000;
  localparam logic [31:0] FSIC_MBOX_BASE     = 32'h3000_2000;
  localparam logic [31:0] FSIC_IOSERDES_BASE = 32'h3000_3000;

  localparam int MAX_REQ = 4;
  localparam int CNT_W   = 10;

  function automatic logic [1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/fsic_wb_arb_if.sv
// Wishbone master-side bus from the arbiter toward the FSIC slave port.
interface fsic_wb_arb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, adr, wdata, sel, input ack, rdata);
  modport slave  (input cyc, stb, we, adr, wdata, sel, output ack, rdata);
endinterface

// File: rtl/fsic_rr_sel.sv
// Round-robin selector: picks the first active requester after last_grant,
// wrapping around, and returns it one-hot.
module fsic_rr_sel #(
  parameter int pNUM_REQ = 2
) (
  input  logic [pNUM_REQ-1:0] req,
  input  logic [1:0]          last_grant,
  output logic [pNUM_REQ-1:0] winner
);

  logic [2*pNUM_REQ-1:0] rot_dbl;
  logic [2*pNUM_REQ-1:0] hit_dbl;
  logic [pNUM_REQ-1:0]   rot;
  logic [pNUM_REQ-1:0]   first;
  logic [2:0]            shamt;

  // Rotate so the requester just after last_grant sits at bit 0, priority-pick,
  // then rotate the one-hot pick back into place.
  assign shamt   = {1'b0, last_grant} + 3'd1;
  assign rot_dbl = {req, req} >> shamt;
  assign rot     = rot_dbl[pNUM_REQ-1:0];

  // NOTE: every combinational output gets a default before the loop so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    first = '0;
    for (int i = pNUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first    = '0;
        first[i] = 1'b1;
      end
    end
  end

  assign hit_dbl = {{pNUM_REQ{1'b0}}, first} << shamt;
  assign winner  = hit_dbl[pNUM_REQ-1:0] | hit_dbl[2*pNUM_REQ-1:pNUM_REQ];

endmodule

// File: rtl/fsic_wb_arb.sv
// Round-robin arbiter granting several Wishbone requesters access to one FSIC
// slave port, with an ack timeout and a one-cycle turnaround between owners.
module fsic_wb_arb
  import fsic_pkg::*;
#(
  parameter int pNUM_REQ = 2,
  parameter int pTIMEOUT = 255
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [pNUM_REQ-1:0]    req_cyc,
  input  logic [pNUM_REQ-1:0]    req_stb,
  input  logic [pNUM_REQ-1:0]    req_we,
  input  logic [32*pNUM_REQ-1:0] req_adr,
  input  logic [32*pNUM_REQ-1:0] req_wdata,
  input  logic [4*pNUM_REQ-1:0]  req_sel,
  output logic [pNUM_REQ-1:0]    req_ack,
  output logic [pNUM_REQ-1:0]    req_err,
  output logic [31:0]            req_rdata,
  fsic_wb_arb_if.master          wbs,
  output logic [pNUM_REQ-1:0]    grant
);

  arb_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            last_grant;
  logic [pNUM_REQ-1:0]   req_vld;
  logic [pNUM_REQ-1:0]   winner;
  logic [31:0]           adr_arr   [pNUM_REQ];
  logic [31:0]           wdata_arr [pNUM_REQ];
  logic [3:0]            sel_arr   [pNUM_REQ];
  logic [31:0]           mux_adr;
  logic [31:0]           mux_wdata;
  logic [3:0]            mux_sel;
  logic                  mux_we;

  assign req_vld = req_cyc & req_stb;

  for (genvar g = 0; g < pNUM_REQ; g++) begin : g_unpack
    assign adr_arr[g]   = req_adr[32*g +: 32];
    assign wdata_arr[g] = req_wdata[32*g +: 32];
    assign sel_arr[g]   = req_sel[4*g +: 4];
  end

  fsic_rr_sel #(.pNUM_REQ(pNUM_REQ)) u_rr_sel (
    .req        (req_vld),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // AND-OR mux keyed by the one-hot winner.
  always_comb begin
    mux_adr   = '0;
    mux_wdata = '0;
    mux_sel   = '0;
    mux_we    = 1'b0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (winner[i]) begin
        mux_adr   = mux_adr   | adr_arr[i];
        mux_wdata = mux_wdata | wdata_arr[i];
        mux_sel   = mux_sel   | sel_arr[i];
        mux_we    = mux_we    | req_we[i];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state      <= ST_IDLE;
      wbs.cyc    <= 1'b0;
      wbs.stb    <= 1'b0;
      wbs.we     <= 1'b0;
      wbs.adr    <= '0;
      wbs.wdata  <= '0;
      wbs.sel    <= '0;
      req_ack    <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      grant      <= '0;
      cnt        <= '0;
      last_grant <= 2'(pNUM_REQ - 1);
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_vld) begin
            state      <= ST_BUSY;
            grant      <= winner;
            last_grant <= oh_to_idx(4'(winner));
            wbs.cyc    <= 1'b1;
            wbs.stb    <= 1'b1;
            wbs.we     <= mux_we;
            wbs.adr    <= mux_adr;
            wbs.wdata  <= mux_wdata;
            wbs.sel    <= mux_sel;
            cnt        <= '0;
          end
        end
        ST_BUSY: begin
          // Ack wins over a timeout landing on the same cycle.
          if (wbs.ack) begin
            state     <= ST_TURN;
            wbs.cyc   <= 1'b0;
            wbs.stb   <= 1'b0;
            req_ack   <= grant;
            req_rdata <= wbs.rdata;
            grant     <= '0;
          end else if (cnt == CNT_W'(pTIMEOUT)) begin
            state   <= ST_TURN;
            wbs.cyc <= 1'b0;
            wbs.stb <= 1'b0;
            req_err <= grant;
            grant   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsic_wb_arb.sv
// Self-checking bench for fsic_wb_arb: directed scenarios followed by randomized
// transfers, checked against a round-robin/timeout reference model.
module tb_fsic_wb_arb;
  import fsic_pkg::*;

  localparam int N  = 2;
  localparam int TO = 8;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [N-1:0]      req_cyc, req_stb, req_we;
  logic [32*N-1:0]   req_adr, req_wdata;
  logic [4*N-1:0]    req_sel;
  logic [N-1:0]      req_ack, req_err, grant;
  logic [31:0]       req_rdata;

  logic              b_act   [N];
  logic              b_we    [N];
  logic [31:0]       b_adr   [N];
  logic [31:0]       b_wdata [N];
  logic [3:0]        b_sel   [N];

  int checks   = 0;
  int failures = 0;
  int last_model;
  int owner;
  int exp_seq [6] = '{0, 1, 0, 1, 0, 1};

  fsic_wb_arb_if wbs ();

  always #5 wb_clk = ~wb_clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_cyc[g]            = b_act[g];
    assign req_stb[g]            = b_act[g];
    assign req_we[g]             = b_we[g];
    assign req_adr[32*g +: 32]   = b_adr[g];
    assign req_wdata[32*g +: 32] = b_wdata[g];
    assign req_sel[4*g +: 4]     = b_sel[g];
  end

  fsic_wb_arb #(.pNUM_REQ(N), .pTIMEOUT(TO)) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .req_cyc   (req_cyc),
    .req_stb   (req_stb),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .wbs       (wbs),
    .grant     (grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic we);
    b_adr[i]   = adr;
    b_wdata[i] = wdata;
    b_sel[i]   = sel;
    b_we[i]    = we;
    b_act[i]   = 1'b1;
  endtask

  // Reference: the active requester closest after the last winner, cyclically.
  function automatic int model_pick();
    int best  = -1;
    int bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      int d = (i - last_model - 1 + 2 * N) % N;
      if (b_act[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    wb_rst = 1'b1;
    tick();
    tick();
    wb_rst = 1'b0;
    last_model = N - 1;
  endtask

  // One transfer: wait for the bus to open, check the winner and its payload,
  // let the slave ack after 'delay' BUSY cycles (never if delay > TO), check the
  // completion pulse. Returns at the turnaround cycle.
  task automatic run_xfer(input int delay, input logic [31:0] rd, input bit drop,
                          input int exp_lat, input bit early_drop, output int who);
    int  lat = 0;
    bit  stable = 1'b1;
    bit  exp_ack;
    logic [31:0] adr0;
    who = model_pick();
    while (!wbs.cyc && lat < 6) begin
      tick();
      lat++;
    end
    check("bus_open", {63'd0, wbs.cyc}, 64'd1);
    if (exp_lat >= 0) check("grant_latency", 64'(lat), 64'(exp_lat));
    if (who < 0) who = 0;
    last_model = who;
    check("grant_onehot", 64'(grant), 64'(1 << who));
    check("wbs_adr", 64'(wbs.adr), 64'(b_adr[who]));
    check("wbs_wdata", 64'(wbs.wdata), 64'(b_wdata[who]));
    check("wbs_sel_we", 64'({wbs.sel, wbs.we, wbs.stb}), 64'({b_sel[who], b_we[who], 1'b1}));
    adr0 = wbs.adr;
    if (early_drop) b_act[who] = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      if (k == delay) begin
        wbs.ack   = 1'b1;
        wbs.rdata = rd;
      end
      tick();
      wbs.ack   = 1'b0;
      wbs.rdata = $urandom;
      if (k == delay || k == TO) break;
      if (!wbs.cyc || wbs.adr !== adr0 || grant !== N'(1 << who)) stable = 1'b0;
    end
    check("busy_stable", {63'd0, stable}, 64'd1);
    exp_ack = (delay <= TO);
    check("req_ack", 64'(req_ack), exp_ack ? 64'(1 << who) : 64'd0);
    check("req_err", 64'(req_err), exp_ack ? 64'd0 : 64'(1 << who));
    if (exp_ack) check("req_rdata", 64'(req_rdata), 64'(rd));
    check("turn_idle_bus", 64'({wbs.cyc, wbs.stb, grant}), 64'd0);
    if (drop) b_act[who] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      b_act[i] = 1'b0; b_we[i] = 1'b0; b_adr[i] = '0; b_wdata[i] = '0; b_sel[i] = '0;
    end
    wbs.ack = 1'b0;
    wbs.rdata = '0;
    wb_rst = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_wbs_ctrl", 64'({wbs.cyc, wbs.stb, wbs.we, wbs.sel}), 64'd0);
    check("rst_wbs_adr", 64'({wbs.adr, wbs.wdata}), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_pulses", 64'({req_ack, req_err}), 64'd0);
    check("rst_rdata", 64'(req_rdata), 64'd0);

    // Single write to IOSERDES, ack after 3 cycles
    set_req(0, FSIC_IOSERDES_BASE, 32'h1, 4'b0001, 1'b1);
    run_xfer(3, 32'h0, 1'b1, 1, 1'b0, owner);
    check("first_owner", 64'(owner), 64'd0);

    // Simultaneous req0/req1 after a fresh reset: req0 first, req1 read follows
    tick();
    do_reset();
    set_req(0, FSIC_MBOX_BASE, 32'hCAFE_0001, 4'b1111, 1'b1);
    set_req(1, FSIC_AA_BASE, 32'h0, 4'b1111, 1'b0);
    run_xfer(2, 32'h1234_5678, 1'b1, 1, 1'b0, owner);
    check("pair_first", 64'(owner), 64'd0);
    run_xfer(1, 32'hA5A5_A5A5, 1'b1, 2, 1'b0, owner);
    check("pair_second", 64'(owner), 64'd1);

    // Timeout with no ack
    set_req(0, FSIC_MBOX_BASE, 32'h55, 4'b0011, 1'b1);
    run_xfer(100, 32'h0, 1'b1, -1, 1'b0, owner);

    // Stray ack while idle produces nothing
    tick();
    tick();
    wbs.ack = 1'b1;
    tick();
    wbs.ack = 1'b0;
    check("idle_ack_ignored", 64'({req_ack, req_err, wbs.cyc}), 64'd0);

    // Reset during BUSY, then req0 must win over req1
    set_req(0, FSIC_IOSERDES_BASE, 32'h77, 4'b0001, 1'b1);
    tick();
    check("pre_rst_busy", {63'd0, wbs.cyc}, 64'd1);
    #2 wb_rst = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({wbs.cyc, wbs.stb, grant, req_ack, req_err}), 64'd0);
    tick();
    wb_rst = 1'b0;
    last_model = N - 1;
    set_req(1, FSIC_AA_BASE, 32'h99, 4'b1000, 1'b1);
    run_xfer(0, 32'h0, 1'b1, -1, 1'b0, owner);
    check("post_rst_owner", 64'(owner), 64'd0);
    run_xfer(TO, 32'hDEAD_BEEF, 1'b1, -1, 1'b0, owner);

    // Both continuously active: strict alternation
    tick();
    tick();
    do_reset();
    set_req(0, FSIC_MBOX_BASE, 32'h100, 4'b1111, 1'b1);
    set_req(1, FSIC_AA_BASE, 32'h200, 4'b1111, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run_xfer(int'($urandom_range(0, 2)), $urandom, 1'b0, -1, 1'b0, owner);
      check("rotation", 64'(owner), 64'(exp_seq[t]));
    end
    b_act[0] = 1'b0;
    b_act[1] = 1'b0;
    tick();
    tick();

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      bit any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!b_act[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom, $urandom, 4'($urandom), 1'($urandom));
        if (b_act[i]) any = 1'b1;
      end
      if (!any) set_req(int'($urandom_range(0, N - 1)), $urandom, $urandom, 4'($urandom), 1'($urandom));
      run_xfer(int'($urandom_range(0, TO + 2)), $urandom, 1'b1, -1,
               ($urandom_range(0, 3) == 0), owner);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
